// File: rtl/bf16_sum_accum.sv
// Streaming BF16 sum-node accumulator: folds a packet of BF16 terms through a
// combinational BF16 adder and hands the total downstream over valid/ready.

module bf16_adder1 (
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic        a_vld,
    input  logic        b_vld,
    output logic [15:0] z,
    output logic        z_vld
);

    logic [15:0] x;
    logic [15:0] y;
    logic [7:0]  ex;
    logic [7:0]  ey;
    logic [7:0]  d;
    logic [10:0] sig_x;
    logic [10:0] sig_y;
    logic [10:0] y_al;
    logic [11:0] sum;
    logic [10:0] n;
    logic [3:0]  lz;
    logic        round_up;
    logic [8:0]  mant;
    int          e_n;

    function automatic logic [3:0] lzc11(input logic [10:0] v);
        lzc11 = 4'd11;
        for (int i = 0; i <= 10; i++) begin
            if (v[i]) lzc11 = 4'(10 - i);
        end
    endfunction

    assign z_vld = a_vld & b_vld;

    // x is always the operand of larger magnitude; subnormals flush to zero,
    // rounding is nearest-even using guard/round/sticky bits.
    always_comb begin
        x        = (b[14:0] > a[14:0]) ? b : a;
        y        = (b[14:0] > a[14:0]) ? a : b;
        ex       = x[14:7];
        ey       = y[14:7];
        d        = ex - ey;
        sig_x    = {1'b1, x[6:0], 3'b000};
        sig_y    = {1'b1, y[6:0], 3'b000};
        y_al     = (sig_y >> d) | {10'd0, |(sig_y & ~(11'h7FF << d))};
        sum      = (x[15] ^ y[15]) ? ({1'b0, sig_x} - {1'b0, y_al})
                                   : ({1'b0, sig_x} + {1'b0, y_al});
        lz       = lzc11(sum[10:0]);
        n        = 11'd0;
        e_n      = 0;
        round_up = 1'b0;
        mant     = 9'd0;
        z        = 16'h0000;

        if (ex == 8'hFF) begin
            if (x[6:0] != 7'd0)
                z = 16'h7FC0;
            else if (ey == 8'hFF && (x[15] ^ y[15]))
                z = 16'h7FC0;
            else
                z = x;
        end else if (ex == 8'd0) begin
            z = {x[15] & y[15], 15'd0};
        end else if (ey == 8'd0) begin
            z = x;
        end else if (sum != 12'd0) begin
            if (sum[11]) begin
                n   = {sum[11:2], sum[1] | sum[0]};
                e_n = int'(ex) + 1;
            end else begin
                n   = sum[10:0] << lz;
                e_n = int'(ex) - int'(lz);
            end
            round_up = n[2] & (n[1] | n[0] | n[3]);
            mant     = {1'b0, n[10:3]} + {8'd0, round_up};
            if (mant[8]) begin
                e_n  = e_n + 1;
                mant = mant >> 1;
            end
            if (e_n >= 255)
                z = {x[15], 8'hFF, 7'd0};
            else if (e_n <= 0)
                z = {x[15], 15'd0};
            else
                z = {x[15], 8'(e_n), mant[6:0]};
        end
    end

endmodule

module bf16_sum_accum #(
    parameter int MAX_LEN = 256,
    parameter int CNT_W   = 9
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [15:0]      in_data,
    input  logic             in_vld,
    input  logic             in_last,
    output logic             in_rdy,
    output logic [15:0]      out_sum,
    output logic [CNT_W-1:0] out_cnt,
    output logic             out_ovf,
    output logic             out_vld,
    input  logic             out_rdy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [15:0]      acc_q, acc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [15:0]      out_sum_q, out_sum_d;
    logic [CNT_W-1:0] out_cnt_q, out_cnt_d;
    logic             out_ovf_q, out_ovf_d;
    logic             out_vld_q, out_vld_d;
    logic             in_rdy_q, in_rdy_d;

    logic [15:0]      add_z;
    logic             add_z_vld;
    logic [CNT_W-1:0] cnt_inc;
    logic             accept;

    bf16_adder1 u_adder (
        .a     (acc_q),
        .b     (in_data),
        .a_vld (1'b1),
        .b_vld (1'b1),
        .z     (add_z),
        .z_vld (add_z_vld)
    );

    // add_z_vld is constant-high because both operand valids are tied off.
    assign accept  = in_vld && in_rdy_q && add_z_vld;
    assign cnt_inc = cnt_q + CNT_W'(1);

    assign in_rdy  = in_rdy_q;
    assign out_sum = out_sum_q;
    assign out_cnt = out_cnt_q;
    assign out_ovf = out_ovf_q;
    assign out_vld = out_vld_q;

    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        out_sum_d = out_sum_q;
        out_cnt_d = out_cnt_q;
        out_ovf_d = out_ovf_q;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    acc_d = add_z;
                    cnt_d = CNT_W'(1);
                    if (in_last || MAX_LEN == 1) begin
                        state_d   = HOLD;
                        out_sum_d = add_z;
                        out_cnt_d = CNT_W'(1);
                        out_ovf_d = !in_last;
                    end else begin
                        state_d = ACC;
                    end
                end
            end
            ACC: begin
                if (accept) begin
                    acc_d = add_z;
                    cnt_d = cnt_inc;
                    // in_last wins over the length limit, so that beat is a normal close
                    if (in_last || cnt_inc == CNT_W'(MAX_LEN)) begin
                        state_d   = HOLD;
                        out_sum_d = add_z;
                        out_cnt_d = cnt_inc;
                        out_ovf_d = !in_last;
                    end
                end
            end
            HOLD: begin
                if (out_rdy) begin
                    state_d   = IDLE;
                    acc_d     = 16'h0000;
                    cnt_d     = '0;
                    out_ovf_d = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
                acc_d   = 16'h0000;
                cnt_d   = '0;
            end
        endcase

        out_vld_d = (state_d == HOLD);
        in_rdy_d  = (state_d != HOLD);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            acc_q     <= 16'h0000;
            cnt_q     <= '0;
            out_sum_q <= 16'h0000;
            out_cnt_q <= '0;
            out_ovf_q <= 1'b0;
            out_vld_q <= 1'b0;
            in_rdy_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            out_sum_q <= out_sum_d;
            out_cnt_q <= out_cnt_d;
            out_ovf_q <= out_ovf_d;
            out_vld_q <= out_vld_d;
            in_rdy_q  <= in_rdy_d;
        end
    end

endmodule

// File: tb/tb_bf16_sum_accum.sv
// Self-checking bench for bf16_sum_accum: directed packets plus random packets
// scored against a real-arithmetic BF16 reference model.

module tb_bf16_sum_accum;

    localparam int MAX_LEN = 4;
    localparam int CNT_W   = 3;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [15:0]      in_data;
    logic             in_vld;
    logic             in_last;
    logic             in_rdy;
    logic [15:0]      out_sum;
    logic [CNT_W-1:0] out_cnt;
    logic             out_ovf;
    logic             out_vld;
    logic             out_rdy;

    int pass_cnt  = 0;
    int check_cnt = 0;

    logic [15:0] mdl_acc;
    int          mdl_cnt;
    logic        mdl_closed;
    logic        mdl_ovf;

    bf16_sum_accum #(.MAX_LEN(MAX_LEN), .CNT_W(CNT_W)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .in_data (in_data),
        .in_vld  (in_vld),
        .in_last (in_last),
        .in_rdy  (in_rdy),
        .out_sum (out_sum),
        .out_cnt (out_cnt),
        .out_ovf (out_ovf),
        .out_vld (out_vld),
        .out_rdy (out_rdy)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, passed %0d of %0d", pass_cnt, check_cnt);
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic real bf16_to_real(input logic [15:0] v);
        logic [63:0] bits;
        if (v[14:7] == 8'd0) return 0.0;
        bits = {v[15], 11'(v[14:7]) + 11'd896, v[6:0], 45'd0};
        return $bitstoreal(bits);
    endfunction

    // Round a real to BF16, nearest-even; values here never reach inf or subnormal.
    function automatic logic [15:0] real_to_bf16(input real r);
        logic [63:0] bits;
        logic [8:0]  keep;
        logic [44:0] rest;
        logic [44:0] half;
        int          be;
        bits = $realtobits(r);
        if (bits[62:52] == 11'd0) return {bits[63], 15'd0};
        be   = int'(bits[62:52]) - 896;
        keep = {2'b01, bits[51:45]};
        rest = bits[44:0];
        half = 45'h1000_0000_0000;
        if (rest > half || (rest == half && keep[0])) keep = keep + 9'd1;
        if (keep[8]) begin
            be   = be + 1;
            keep = keep >> 1;
        end
        if (be >= 255) return {bits[63], 8'hFF, 7'd0};
        if (be <= 0) return {bits[63], 15'd0};
        return {bits[63], 8'(be), keep[6:0]};
    endfunction

    function automatic logic [15:0] rand_bf16();
        logic [15:0] v;
        v[15]   = 1'($urandom_range(0, 1));
        v[14:7] = 8'($urandom_range(118, 136));
        v[6:0]  = 7'($urandom_range(0, 127));
        return v;
    endfunction

    task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        check_cnt++;
        assert (observed === expected) pass_cnt++;
        else $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    endtask

    task automatic model_clear();
        mdl_acc    = 16'h0000;
        mdl_cnt    = 0;
        mdl_closed = 1'b0;
        mdl_ovf    = 1'b0;
    endtask

    task automatic check_hold(input string tag);
        check_output({tag, "_vld"}, 32'(out_vld), 32'd1);
        check_output({tag, "_sum"}, 32'(out_sum), 32'(mdl_acc));
        check_output({tag, "_cnt"}, 32'(out_cnt), 32'(mdl_cnt));
        check_output({tag, "_ovf"}, 32'(out_ovf), 32'(mdl_ovf));
        check_output({tag, "_rdy"}, 32'(in_rdy), 32'd0);
    endtask

    // Present one beat as soon as the block is ready; time is posedge+1 on entry and exit.
    task automatic apply_stimulus(input string tag, input logic [15:0] data, input logic last);
        int n = 0;
        while (in_rdy !== 1'b1 && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 20) check_output({tag, "_rdy_timeout"}, 32'(in_rdy), 32'd1);
        in_data = data;
        in_vld  = 1'b1;
        in_last = last;
        @(posedge clk); #1;
        in_vld  = 1'b0;
        in_last = 1'b0;
        mdl_acc = real_to_bf16(bf16_to_real(mdl_acc) + bf16_to_real(data));
        mdl_cnt++;
        if (last || mdl_cnt == MAX_LEN) begin
            mdl_closed = 1'b1;
            mdl_ovf    = !last;
            check_hold(tag);
        end
    endtask

    task automatic drain(input string tag, input int stall, input logic poke);
        logic [15:0]      held_sum;
        logic [CNT_W-1:0] held_cnt;
        held_sum = mdl_acc;
        held_cnt = CNT_W'(mdl_cnt);
        out_rdy  = 1'b0;
        for (int i = 0; i < stall; i++) begin
            if (poke) begin
                in_vld  = 1'b1;
                in_last = 1'($urandom_range(0, 1));
                in_data = rand_bf16();
            end
            @(posedge clk); #1;
            check_output({tag, "_stall_vld"}, 32'(out_vld), 32'd1);
            check_output({tag, "_stall_sum"}, 32'(out_sum), 32'(held_sum));
            check_output({tag, "_stall_cnt"}, 32'(out_cnt), 32'(held_cnt));
            check_output({tag, "_stall_rdy"}, 32'(in_rdy), 32'd0);
        end
        out_rdy = 1'b1;
        @(posedge clk); #1;
        out_rdy = 1'b0;
        in_vld  = 1'b0;
        in_last = 1'b0;
        check_output({tag, "_drain_vld"}, 32'(out_vld), 32'd0);
        check_output({tag, "_drain_rdy"}, 32'(in_rdy), 32'd1);
        model_clear();
    endtask

    initial begin
        rst_n   = 1'b0;
        in_data = 16'h0000;
        in_vld  = 1'b0;
        in_last = 1'b0;
        out_rdy = 1'b0;
        model_clear();

        #12;
        check_output("reset_rdy", 32'(in_rdy), 32'd0);
        check_output("reset_vld", 32'(out_vld), 32'd0);
        check_output("reset_sum", 32'(out_sum), 32'd0);
        check_output("reset_cnt", 32'(out_cnt), 32'd0);
        check_output("reset_ovf", 32'(out_ovf), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check_output("release_rdy", 32'(in_rdy), 32'd1);

        apply_stimulus("single", 16'h3F80, 1'b1);
        check_output("single_const_sum", 32'(out_sum), 32'h3F80);
        drain("single", 0, 1'b0);

        apply_stimulus("three_a", 16'h3F80, 1'b0);
        apply_stimulus("three_b", 16'h4000, 1'b0);
        apply_stimulus("three", 16'h4040, 1'b1);
        check_output("three_const_sum", 32'(out_sum), 32'h40C0);
        check_output("three_const_cnt", 32'(out_cnt), 32'd3);
        drain("backpressure", 5, 1'b1);

        apply_stimulus("gap_a", 16'h3F00, 1'b0);
        for (int i = 0; i < 3; i++) begin
            in_last = 1'b1;
            @(posedge clk); #1;
            in_last = 1'b0;
            check_output("gap_idle_vld", 32'(out_vld), 32'd0);
            check_output("gap_idle_rdy", 32'(in_rdy), 32'd1);
        end
        apply_stimulus("gap", 16'h3F00, 1'b1);
        check_output("gap_const_sum", 32'(out_sum), 32'h3F80);
        check_output("gap_const_cnt", 32'(out_cnt), 32'd2);
        drain("gap", 1, 1'b0);

        for (int i = 0; i < 4; i++) apply_stimulus("ovf", 16'h3F80, 1'b0);
        check_output("ovf_const_sum", 32'(out_sum), 32'h4080);
        check_output("ovf_const_flag", 32'(out_ovf), 32'd1);
        drain("ovf", 2, 1'b0);
        apply_stimulus("ovf_tail", 16'h3F80, 1'b1);
        check_output("ovf_tail_const_sum", 32'(out_sum), 32'h3F80);
        check_output("ovf_tail_const_flag", 32'(out_ovf), 32'd0);
        drain("ovf_tail", 0, 1'b0);

        for (int i = 0; i < 3; i++) apply_stimulus("last_at_max", 16'h4000, 1'b0);
        apply_stimulus("last_at_max", 16'h4000, 1'b1);
        check_output("last_at_max_ovf", 32'(out_ovf), 32'd0);
        drain("last_at_max", 0, 1'b0);

        apply_stimulus("rst_a", 16'h4000, 1'b0);
        apply_stimulus("rst_b", 16'h4000, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        check_output("rst_mid_vld", 32'(out_vld), 32'd0);
        check_output("rst_mid_rdy", 32'(in_rdy), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        model_clear();
        @(posedge clk); #1;
        apply_stimulus("rst_after", 16'h3F80, 1'b1);
        check_output("rst_after_const_cnt", 32'(out_cnt), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check_output("rst_hold_vld", 32'(out_vld), 32'd0);
        check_output("rst_hold_sum", 32'(out_sum), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        model_clear();
        @(posedge clk); #1;

        for (int p = 0; p < 40; p++) begin
            int len;
            len = int'($urandom_range(1, 6));
            for (int i = 0; i < len; i++) begin
                int gap;
                gap = int'($urandom_range(0, 2));
                for (int g = 0; g < gap; g++) begin
                    in_last = 1'($urandom_range(0, 1));
                    @(posedge clk); #1;
                    in_last = 1'b0;
                end
                apply_stimulus("rand", rand_bf16(), (i == len - 1));
                if (mdl_closed) drain("rand", int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
            end
        end

        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule
